// File: rtl/id_decode_stage.sv
// IF->ID stage: pre-decodes opcode into immediate type and register fields, 2-entry skid buffer.
// Optional CSR immediate decode enabled by defining ID_CSR_DECODE_EN.
module id_decode_stage #(
   parameter int PC_W = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            in_valid_in,
   output logic            in_ready_out,
   input  logic [31:0]     instr_in,
   input  logic [PC_W-1:0] pc_in,
   input  logic            flush_in,
   output logic            out_valid_out,
   input  logic            out_ready_in,
   output logic [31:0]     instr_out,
   output logic [PC_W-1:0] pc_out,
   output logic [2:0]      imm_type_out,
   output logic [4:0]      rs1_out,
   output logic [4:0]      rs2_out,
   output logic [4:0]      rd_out,
   output logic            illegal_out
);

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic [2:0]      imm_type;
      logic            illegal;
   } entry_t;

   // Returns {illegal, imm_type}; every legal opcode ends in 2'b11, so compressed encodings fall to default.
   function automatic logic [3:0] decode_fn(input logic [31:0] instr);
      logic [2:0] f3;
      f3 = instr[14:12];
      decode_fn = {1'b1, 3'b000};
      case (instr[6:0])
         7'b0010011: decode_fn = {1'b0, 3'b000};
         7'b0000011: decode_fn = {1'b0, 3'b001};
         7'b0100011: decode_fn = {1'b0, 3'b010};
         7'b1100011: decode_fn = {1'b0, 3'b011};
         7'b0110111: decode_fn = {1'b0, 3'b100};
         7'b0010111: decode_fn = {1'b0, 3'b100};
         7'b1101111: decode_fn = {1'b0, 3'b101};
         7'b1100111: decode_fn = {1'b0, 3'b111};
         7'b0110011: decode_fn = {1'b0, 3'b000};
         7'b0001111: decode_fn = {1'b0, 3'b000};
         7'b1110011: begin
            if (f3 == 3'b000) begin
               decode_fn = {1'b0, 3'b000};
            end else begin
`ifdef ID_CSR_DECODE_EN
               case (f3)
                  3'b001, 3'b010, 3'b011: decode_fn = {1'b0, 3'b000};
                  3'b101, 3'b110, 3'b111: decode_fn = {1'b0, 3'b110};
                  default:                decode_fn = {1'b1, 3'b000};
               endcase
`else
               decode_fn = {1'b1, 3'b000};
`endif
            end
         end
         default: decode_fn = {1'b1, 3'b000};
      endcase
   endfunction

   entry_t main_q, main_d, skid_q, skid_d, in_entry_s;
   logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
   logic   accept_s, consume_s;
   logic [3:0] dec_s;

   assign accept_s  = in_valid_in & rdy_q;
   assign consume_s = main_vld_q & out_ready_in;

   // Decode the incoming instruction so the result is stored alongside it.
   always_comb begin
      dec_s               = decode_fn(instr_in);
      in_entry_s.instr    = instr_in;
      in_entry_s.pc       = pc_in;
      in_entry_s.imm_type = dec_s[2:0];
      in_entry_s.illegal  = dec_s[3];
   end

   // Skid buffer next state; skid always drains into main before newer input.
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush_in) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (consume_s || !main_vld_q) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept_s) begin
            main_d     = in_entry_s;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept_s) begin
         skid_d     = in_entry_s;
         skid_vld_d = 1'b1;
      end else begin
         skid_vld_d = skid_vld_q;
      end
      rdy_d = ~skid_vld_d;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
      end
   end

   assign in_ready_out  = rdy_q;
   assign out_valid_out = main_vld_q;
   assign instr_out     = main_q.instr;
   assign pc_out        = main_q.pc;
   assign imm_type_out  = main_q.imm_type;
   assign illegal_out   = main_q.illegal;
   assign rs1_out       = main_q.instr[19:15];
   assign rs2_out       = main_q.instr[24:20];
   assign rd_out        = main_q.instr[11:7];

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vector table plus skid, flush and reset sequences.
module tb_id_decode_stage;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
   logic [31:0] instr_i, instr_o, pc_i, pc_o;
   logic [2:0]  imm_type;
   logic [4:0]  rs1, rs2, rd;
   int          n_tests = 0;
   int          n_fail  = 0;

   id_decode_stage #(.PC_W(32)) dut (
      .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid), .in_ready_out(in_ready),
      .instr_in(instr_i), .pc_in(pc_i), .flush_in(flush), .out_valid_out(out_valid),
      .out_ready_in(out_ready), .instr_out(instr_o), .pc_out(pc_o), .imm_type_out(imm_type),
      .rs1_out(rs1), .rs2_out(rs2), .rd_out(rd), .illegal_out(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  imm;
      logic        ill;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid = v;
      instr_i  = ins;
      pc_i     = pc;
   endtask

   initial begin
      vecs[0]  = '{32'h00500093, 3'b000, 1'b0, 5'd0,  5'd5, 5'd1};
      vecs[1]  = '{32'h00112623, 3'b010, 1'b0, 5'd2,  5'd1, 5'd12};
      vecs[2]  = '{32'h00208463, 3'b011, 1'b0, 5'd1,  5'd2, 5'd8};
      vecs[3]  = '{32'h123450B7, 3'b100, 1'b0, 5'd8,  5'd3, 5'd1};
      vecs[4]  = '{32'h008000EF, 3'b101, 1'b0, 5'd0,  5'd8, 5'd1};
      vecs[5]  = '{32'h000080E7, 3'b111, 1'b0, 5'd1,  5'd0, 5'd1};
      vecs[6]  = '{32'h0000A103, 3'b001, 1'b0, 5'd1,  5'd0, 5'd2};
      vecs[7]  = '{32'h0000000B, 3'b000, 1'b1, 5'd0,  5'd0, 5'd0};
      vecs[8]  = '{32'h00000010, 3'b000, 1'b1, 5'd0,  5'd0, 5'd0};
`ifdef ID_CSR_DECODE_EN
      vecs[9]  = '{32'h3002D0F3, 3'b110, 1'b0, 5'd5,  5'd0, 5'd1};
`else
      vecs[9]  = '{32'h3002D0F3, 3'b000, 1'b1, 5'd5,  5'd0, 5'd1};
`endif
      vecs[10] = '{32'h00000033, 3'b000, 1'b0, 5'd0,  5'd0, 5'd0};
      vecs[11] = '{32'h0000000F, 3'b000, 1'b0, 5'd0,  5'd0, 5'd0};
      vecs[12] = '{32'h00000073, 3'b000, 1'b0, 5'd0,  5'd0, 5'd0};
      vecs[13] = '{32'h00000017, 3'b100, 1'b0, 5'd0,  5'd0, 5'd0};
      vecs[14] = '{32'h00004073, 3'b000, 1'b1, 5'd0,  5'd0, 5'd0};
      vecs[15] = '{32'h0000007F, 3'b000, 1'b1, 5'd0,  5'd0, 5'd0};

      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_imm_ill", {28'd0, illegal, imm_type}, 32'd0);

      // Back-to-back stream: each vector appears exactly one cycle after it is driven.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vecs[i].instr, 32'h100 + 32'(i * 4));
         tick();
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, 32'd1);
         chk($sformatf("v%0d_instr", i), instr_o, vecs[i].instr);
         chk($sformatf("v%0d_pc", i), pc_o, 32'h100 + 32'(i * 4));
         chk($sformatf("v%0d_imm", i), {29'd0, imm_type}, {29'd0, vecs[i].imm});
         chk($sformatf("v%0d_ill", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
         chk($sformatf("v%0d_regs", i), {17'd0, rs1, rs2, rd},
             {17'd0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // Stall: A in main, B in skid, C held off until the buffer drains.
      out_ready = 1'b0;
      drive(1'b1, 32'h00A00093, 32'h200);
      tick();
      chk("stall_a_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_a_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h00B00093, 32'h204);
      tick();
      chk("stall_skid_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 32'h00C00093, 32'h208);
      tick(); tick();
      chk("stall_hold_instr", instr_o, 32'h00A00093);
      chk("stall_hold_pc", pc_o, 32'h200);
      chk("stall_hold_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("drain_b_instr", instr_o, 32'h00B00093);
      chk("drain_b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("drain_c_instr", instr_o, 32'h00C00093);
      chk("drain_c_pc", pc_o, 32'h208);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("drain_empty", {31'd0, out_valid}, 32'd0);

      // Flush with both entries full and a new input offered.
      out_ready = 1'b0;
      drive(1'b1, 32'h00D00093, 32'h300);
      tick();
      drive(1'b1, 32'h00E00093, 32'h304);
      tick();
      drive(1'b1, 32'h00F00093, 32'h308);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();
      chk("flush_nothing_left", {31'd0, out_valid}, 32'd0);

      // Flush while main is full and an input is being accepted: the input is dropped.
      out_ready = 1'b0;
      drive(1'b1, 32'h01000093, 32'h400);
      tick();
      drive(1'b1, 32'h01100093, 32'h404);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1;
      chk("flush_acc_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("flush_acc_dropped", {31'd0, out_valid}, 32'd0);

      // Reset mid-transfer discards both entries.
      out_ready = 1'b0;
      drive(1'b1, 32'h01200093, 32'h500);
      tick();
      drive(1'b1, 32'h01300093, 32'h504);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mid_instr", instr_o, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("rst_mid_empty", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
